// File: rtl/microprocessor_pkg.sv
// -----------------------------------------------------------------------------
// microprocessor_pkg
// Types and constants shared between the pipeline stages of the core.
//   fetch_state_t : fetch-unit FSM state (FETCH, HOLD, DISCARD)
//   if_id_t       : payload carried by the IF/ID pipeline register
//   WORD_WIDTH, NOP_INSTRUCTION, RESET_VECTOR, IF_ID_WIDTH
// -----------------------------------------------------------------------------
package microprocessor_pkg;

    localparam int                    WORD_WIDTH      = 32;
    localparam logic [WORD_WIDTH-1:0] NOP_INSTRUCTION = 32'h0000_0000;
    localparam logic [WORD_WIDTH-1:0] RESET_VECTOR    = 32'h0000_0000;
    localparam logic [WORD_WIDTH-1:0] INSTR_BYTES     = 32'd4;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,  // request outstanding at PC
        HOLD    = 2'd1,  // fetched word parked in the hold buffer during a stall
        DISCARD = 2'd2   // stale request in flight after a redirect; drop its word
    } fetch_state_t;

    typedef struct packed {
        logic [WORD_WIDTH-1:0] instruction;
        logic [WORD_WIDTH-1:0] pc_plus4;
        logic                  valid;
    } if_id_t;

    localparam int IF_ID_WIDTH = $bits(if_id_t);

endpackage : microprocessor_pkg

// File: rtl/if_id_register.sv
// -----------------------------------------------------------------------------
// if_id_register
// Generic pipeline register with write-enable and flush. Flush clears the
// payload to all zeros (a bubble) and wins over write-enable. Width is a
// parameter so the same block serves IF/ID and ID/EX.
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-high reset (clears payload)
//   write_en_i in   1 = load data_i, 0 = hold
//   flush_i    in   1 = load zeros regardless of write_en_i
//   data_i     in   WIDTH-bit payload
//   data_o     out  WIDTH-bit registered payload
// -----------------------------------------------------------------------------
module if_id_register #(
    parameter int WIDTH = 65
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             write_en_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] data_q;

    // NOTE: sequential state is always written with non-blocking (<=) so every
    // flop samples its inputs from before the edge, independent of block order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= '0;
        end else if (flush_i) begin
            data_q <= '0;
        end else if (write_en_i) begin
            data_q <= data_i;
        end
    end

    assign data_o = data_q;

endmodule : if_id_register

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
// IF stage: owns the PC, issues instruction-memory reads, and fills the IF/ID
// register. A word that returns while decode is stalled is parked in a hold
// buffer; a redirect that arrives while a read is in flight lets that read
// finish at its original address and throws the returned word away.
//   clk               in   rising-edge clock
//   reset             in   asynchronous active-high reset
//   pcWrite           in   0 = hold PC (stall)
//   ifIdWrite         in   0 = hold IF/ID (stall)
//   branchTaken       in   redirect pulse, beats every other event
//   branchTarget      in   redirect address
//   memRead           out  instruction-memory read request
//   memAddress        out  instruction-memory address
//   memReady          in   memData valid this cycle
//   memData           in   fetched instruction word
//   programCounterOut out  PC+4 of the IF/ID instruction
//   instruction       out  IF/ID instruction
//   instructionValid  out  0 = bubble
// -----------------------------------------------------------------------------
module instruction_fetch
    import microprocessor_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pcWrite,
    input  logic                  ifIdWrite,
    input  logic                  branchTaken,
    input  logic [WORD_WIDTH-1:0] branchTarget,
    output logic                  memRead,
    output logic [WORD_WIDTH-1:0] memAddress,
    input  logic                  memReady,
    input  logic [WORD_WIDTH-1:0] memData,
    output logic [WORD_WIDTH-1:0] programCounterOut,
    output logic [WORD_WIDTH-1:0] instruction,
    output logic                  instructionValid
);

    fetch_state_t          state_q, state_d;
    logic [WORD_WIDTH-1:0] pc_q, pc_d;
    logic [WORD_WIDTH-1:0] hold_q, hold_d;
    // Address of the read still in flight while in DISCARD; PC already holds
    // the redirect target at that point.
    logic [WORD_WIDTH-1:0] discard_addr_q, discard_addr_d;

    logic                  stall;
    logic [WORD_WIDTH-1:0] pc_plus4;
    logic                  if_id_we;
    logic                  if_id_flush;
    if_id_t                if_id_d;
    if_id_t                if_id_q;
    logic [IF_ID_WIDTH-1:0] if_id_raw;

    assign stall    = !pcWrite || !ifIdWrite;
    assign pc_plus4 = pc_q + INSTR_BYTES;  // wraps modulo 2^32

    // NOTE: every signal assigned in this block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        hold_d         = hold_q;
        discard_addr_d = discard_addr_q;
        if_id_we       = 1'b0;
        if_id_flush    = 1'b0;
        if_id_d        = '{instruction: NOP_INSTRUCTION, pc_plus4: pc_q, valid: 1'b0};

        if (branchTaken) begin
            pc_d        = branchTarget;
            hold_d      = NOP_INSTRUCTION;
            if_id_flush = 1'b1;
            unique case (state_q)
                HOLD: state_d = FETCH;
                FETCH: begin
                    if (memReady) begin
                        state_d = FETCH;
                    end else begin
                        // Read to pc_q is still in flight; remember where it went.
                        state_d        = DISCARD;
                        discard_addr_d = pc_q;
                    end
                end
                // Already discarding: the in-flight address stays, only the
                // target (in PC) moves. If the stale word lands now, we're done.
                DISCARD: state_d = memReady ? FETCH : DISCARD;
                default: state_d = FETCH;
            endcase
        end else begin
            unique case (state_q)
                FETCH: begin
                    if (memReady) begin
                        if (!stall) begin
                            if_id_we = 1'b1;
                            if_id_d  = '{instruction: memData, pc_plus4: pc_plus4, valid: 1'b1};
                            pc_d     = pc_plus4;
                        end else begin
                            hold_d  = memData;
                            state_d = HOLD;
                        end
                    end else if (!stall) begin
                        if_id_we = 1'b1;  // bubble from the default payload
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        if_id_we = 1'b1;
                        if_id_d  = '{instruction: hold_q, pc_plus4: pc_plus4, valid: 1'b1};
                        pc_d     = pc_plus4;
                        state_d  = FETCH;
                    end
                end
                DISCARD: begin
                    if (!stall) begin
                        if_id_we = 1'b1;  // bubble
                    end
                    // The stale word is dropped; PC already points at the target.
                    if (memReady) begin
                        state_d = FETCH;
                    end
                end
                default: state_d = FETCH;
            endcase
        end
    end

    // NOTE: the hold buffer is a plain register, not a memory, so it is reset
    // along with the rest of the state and never exposes X.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= FETCH;
            pc_q           <= RESET_VECTOR;
            hold_q         <= NOP_INSTRUCTION;
            discard_addr_q <= RESET_VECTOR;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            hold_q         <= hold_d;
            discard_addr_q <= discard_addr_d;
        end
    end

    if_id_register #(
        .WIDTH(IF_ID_WIDTH)
    ) u_if_id (
        .clk       (clk),
        .reset     (reset),
        .write_en_i(if_id_we),
        .flush_i   (if_id_flush),
        .data_i    (if_id_d),
        .data_o    (if_id_raw)
    );

    assign if_id_q           = if_id_t'(if_id_raw);
    assign instruction       = if_id_q.instruction;
    assign programCounterOut = if_id_q.pc_plus4;
    assign instructionValid  = if_id_q.valid;

    // Reset gates the request directly so no read is issued while held in reset.
    assign memRead    = !reset && (state_q != HOLD);
    assign memAddress = (state_q == DISCARD) ? discard_addr_q : pc_q;

endmodule : instruction_fetch

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
// Directed bench for instruction_fetch. The memory model returns
// address ^ 32'h5A00_0000 unless an explicit word override is selected.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        pcWrite;
    logic        ifIdWrite;
    logic        branchTaken;
    logic [31:0] branchTarget;
    logic        memRead;
    logic [31:0] memAddress;
    logic        memReady;
    logic [31:0] memData;
    logic [31:0] programCounterOut;
    logic [31:0] instruction;
    logic        instructionValid;

    logic        custom_en;
    logic [31:0] custom_word;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign memData = custom_en ? custom_word : (memAddress ^ 32'h5A00_0000);

    instruction_fetch dut (
        .clk              (clk),
        .reset            (reset),
        .pcWrite          (pcWrite),
        .ifIdWrite        (ifIdWrite),
        .branchTaken      (branchTaken),
        .branchTarget     (branchTarget),
        .memRead          (memRead),
        .memAddress       (memAddress),
        .memReady         (memReady),
        .memData          (memData),
        .programCounterOut(programCounterOut),
        .instruction      (instruction),
        .instructionValid (instructionValid)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Advance one clock and sample 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] instr, input logic [31:0] pco,
                              input logic valid);
        check({tag, ".instr"}, instruction, instr);
        check({tag, ".pc"}, programCounterOut, pco);
        check({tag, ".valid"}, {31'd0, instructionValid}, {31'd0, valid});
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".memRead"}, {31'd0, memRead}, 32'd0);
        check({tag, ".memAddress"}, memAddress, 32'h0);
        check_ifid(tag, 32'h0, 32'h0, 1'b0);
    endtask

    initial begin
        reset        = 1'b1;
        pcWrite      = 1'b1;
        ifIdWrite    = 1'b1;
        branchTaken  = 1'b0;
        branchTarget = 32'h0;
        memReady     = 1'b0;
        custom_en    = 1'b0;
        custom_word  = 32'h0;

        // ---- Reset state ----
        tick();
        tick();
        check_reset_outputs("reset");
        reset = 1'b0;
        #1;
        check("post_reset.memRead", {31'd0, memRead}, 32'd1);
        check("post_reset.memAddress", memAddress, 32'h0);

        // ---- Back-to-back fetches with memReady tied high ----
        memReady = 1'b1;
        tick();
        check_ifid("seq0", 32'h5A00_0000, 32'h4, 1'b1);
        check("seq0.memAddress", memAddress, 32'h4);
        tick();
        check_ifid("seq1", 32'h5A00_0004, 32'h8, 1'b1);
        tick();
        check_ifid("seq2", 32'h5A00_0008, 32'hC, 1'b1);
        check("seq2.memAddress", memAddress, 32'hC);

        // ---- memReady delayed 3 cycles after a fresh reset ----
        memReady = 1'b0;
        reset    = 1'b1;
        #1;
        check_reset_outputs("reset2");
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("wait.memAddress", memAddress, 32'h0);
            check("wait.memRead", {31'd0, memRead}, 32'd1);
            check("wait.valid", {31'd0, instructionValid}, 32'd0);
        end
        memReady = 1'b1;
        tick();
        check_ifid("late", 32'h5A00_0000, 32'h4, 1'b1);

        // ---- IF/ID stall while word 0x00011020 returns ----
        custom_en   = 1'b1;
        custom_word = 32'h0001_1020;
        ifIdWrite   = 1'b0;
        tick();
        check("stall0.memRead", {31'd0, memRead}, 32'd0);
        check_ifid("stall0", 32'h5A00_0000, 32'h4, 1'b1);
        memReady = 1'b0;
        tick();
        check("stall1.memRead", {31'd0, memRead}, 32'd0);
        check_ifid("stall1", 32'h5A00_0000, 32'h4, 1'b1);
        ifIdWrite = 1'b1;
        tick();
        check_ifid("release", 32'h0001_1020, 32'h8, 1'b1);
        check("release.memRead", {31'd0, memRead}, 32'd1);
        check("release.memAddress", memAddress, 32'h8);
        custom_en = 1'b0;
        tick();
        check_ifid("no_dup", 32'h0, 32'h8, 1'b0);

        // ---- Redirect while the read to 8 is outstanding ----
        branchTaken  = 1'b1;
        branchTarget = 32'h0000_0100;
        tick();
        branchTaken = 1'b0;
        check("disc0.memAddress", memAddress, 32'h8);
        check("disc0.memRead", {31'd0, memRead}, 32'd1);
        check("disc0.valid", {31'd0, instructionValid}, 32'd0);
        tick();
        check("disc1.memAddress", memAddress, 32'h8);
        check("disc1.valid", {31'd0, instructionValid}, 32'd0);
        memReady = 1'b1;
        tick();
        check("drop.valid", {31'd0, instructionValid}, 32'd0);
        check("drop.instr", instruction, 32'h0);
        check("drop.memAddress", memAddress, 32'h0000_0100);
        tick();
        check_ifid("target", 32'h5A00_0100, 32'h104, 1'b1);

        // ---- Redirect during a PC stall ----
        memReady     = 1'b0;
        pcWrite      = 1'b0;
        branchTaken  = 1'b1;
        branchTarget = 32'h0000_0200;
        tick();
        branchTaken = 1'b0;
        check("stall_br.valid", {31'd0, instructionValid}, 32'd0);
        check("stall_br.instr", instruction, 32'h0);
        check("stall_br.memAddress", memAddress, 32'h104);
        pcWrite  = 1'b1;
        memReady = 1'b1;
        tick();
        check("stall_br.next_addr", memAddress, 32'h200);
        check("stall_br.drop_valid", {31'd0, instructionValid}, 32'd0);
        tick();
        check_ifid("stall_br.target", 32'h5A00_0200, 32'h204, 1'b1);

        // ---- PC wrap at 0xFFFF_FFFC ----
        branchTaken  = 1'b1;
        branchTarget = 32'hFFFF_FFFC;
        tick();
        branchTaken = 1'b0;
        check("wrap.memAddress", memAddress, 32'hFFFF_FFFC);
        check("wrap.flush_valid", {31'd0, instructionValid}, 32'd0);
        tick();
        check_ifid("wrap", 32'hA5FF_FFFC, 32'h0, 1'b1);
        check("wrap.next_addr", memAddress, 32'h0);

        // ---- Reset in the middle of DISCARD ----
        memReady     = 1'b0;
        branchTaken  = 1'b1;
        branchTarget = 32'h0000_0300;
        tick();
        branchTaken = 1'b0;
        check("mid_disc.memAddress", memAddress, 32'h0);
        check("mid_disc.valid", {31'd0, instructionValid}, 32'd0);
        reset = 1'b1;
        #1;
        check_reset_outputs("mid_disc_reset");
        memReady = 1'b1;
        tick();
        check_reset_outputs("reset_ready_ignored");
        memReady = 1'b0;
        reset    = 1'b0;
        #1;
        check("after_reset.memRead", {31'd0, memRead}, 32'd1);
        check("after_reset.memAddress", memAddress, 32'h0);
        memReady = 1'b1;
        tick();
        check_ifid("after_reset", 32'h5A00_0000, 32'h4, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_instruction_fetch
